// File: rtl/memory_arbiter_if.sv
// Request/response bundle between the CPU request unit, the memory arbiter and the single-port RAM.
// slave = arbiter side, master = environment (datapath + RAM) side.
interface memory_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;
    logic        merr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, merr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, merr
    );
endinterface

// File: rtl/memory_arbiter.sv
// Serialises data and instruction requests onto one RAM port, data first, with a watchdog
// that forces completion after TIMEOUT cycles and latches a sticky error flag.
module memory_arbiter #(
    parameter int          TIMEOUT = 16,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic             CLK,
    input  logic             RST,
    memory_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DACC, IACC} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          merr_q, merr_d;

    logic d_req;
    logic d_rd;
    logic expired;

    assign d_req   = bus.dREN | bus.dWEN;
    assign d_rd    = bus.dREN & ~bus.dWEN;
    assign expired = (cnt_q == CNT_LAST) & ~bus.ramready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            merr_q  <= merr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        merr_d       = merr_q;
        bus.ihit     = 1'b0;
        bus.iload    = '0;
        bus.dhit     = 1'b0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.merr     = merr_q;

        unique case (state_q)
            IDLE: begin
                if (d_req)         state_d = DACC;
                else if (bus.iREN) state_d = IACC;
            end
            DACC: begin
                // a simultaneous read+write request is serviced as a write
                bus.ramREN   = d_rd;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (!d_req) begin
                    state_d = IDLE;
                end else if (bus.ramready || expired) begin
                    bus.dhit = 1'b1;
                    state_d  = IDLE;
                    if (d_rd)          bus.dload = bus.ramready ? bus.ramload : ERRWORD;
                    if (!bus.ramready) merr_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IACC: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (bus.ramready || expired) begin
                    bus.ihit  = 1'b1;
                    bus.iload = bus.ramready ? bus.ramload : ERRWORD;
                    state_d   = IDLE;
                    if (!bus.ramready) merr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
